// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants and enumerations for the burst memory
//                controller (burst length, controller states, grant codes).
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int BURST_LEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BEAT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_DWR  = 2'd1,
    G_DRD  = 2'd2,
    G_IRD  = 2'd3
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_if
//  Description : Cache-side bus of the memory controller.
//                d_write_* : dcache write-back burst (req/addr/data in, val out)
//                d_read_*  : dcache refill burst (req/addr in, data/val out)
//                i_read_*  : icache refill burst (req/addr in, data/val out)
//                master = cache side, slave = controller side.
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_ctrl_if;

  logic        d_write_req;
  logic [31:0] d_write_addr;
  logic [31:0] d_write_data;
  logic        d_write_val;

  logic        d_read_req;
  logic [31:0] d_read_addr;
  logic [31:0] d_read_data;
  logic        d_read_val;

  logic        i_read_req;
  logic [31:0] i_read_addr;
  logic [31:0] i_read_data;
  logic        i_read_val;

  modport master (
    output d_write_req, d_write_addr, d_write_data,
    output d_read_req, d_read_addr,
    output i_read_req, i_read_addr,
    input  d_write_val, d_read_data, d_read_val, i_read_data, i_read_val
  );

  modport slave (
    input  d_write_req, d_write_addr, d_write_data,
    input  d_read_req, d_read_addr,
    input  i_read_req, i_read_addr,
    output d_write_val, d_read_data, d_read_val, i_read_data, i_read_val
  );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : MEM_DEPTH x 32 word store. Synchronous write, combinational
//                read, no reset (contents survive controller reset).
//  Ports       : clk, wr_en/wr_idx/wr_data (write), rd_idx/rd_data (read)
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
module mem_array #(
  parameter int MEM_DEPTH = 4096,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Three-requester burst memory controller. Each grant moves an
//                8-beat block; every beat waits ACCESS_LAT cycles then spends
//                one BEAT cycle with the granted val high.
//  Ports       : clk   - clock
//                reset - asynchronous, active-high
//                bus   - mem_ctrl_if.slave (dcache write/read, icache read)
//  Macros      : MEMCTL_RR_EN - round-robin arbitration (default: fixed
//                priority d_write > d_read > i_read)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ACCESS_LAT = 2,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);

  localparam int         AW       = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT_LAST = 4'(ACCESS_LAT - 1);

  state_t      state_q, state_d;
  grant_t      grant_q, grant_d;
  logic [26:0] blk_q, blk_d;       // block address bits [31:5]
  logic [2:0]  beat_q, beat_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] d_rd_q, d_rd_d;
  logic [31:0] i_rd_q, i_rd_d;
`ifdef MEMCTL_RR_EN
  grant_t      last_q, last_d;
`endif

  grant_t      w_pick;
  logic [26:0] w_pick_blk;
  logic        w_granted_req;
  logic        w_wr_en;
  logic [29:0] w_word;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_data;
  logic        w_unused;

  // Word address of the current beat; the array index is its low AW bits.
  assign w_word = {blk_q, beat_q};
  assign w_idx  = w_word[AW-1:0];
  assign w_unused = ^{bus.d_write_addr[4:0], bus.d_read_addr[4:0],
                      bus.i_read_addr[4:0], w_word};

  mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_array (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_idx  (w_idx),
    .wr_data (bus.d_write_data),
    .rd_idx  (w_idx),
    .rd_data (w_rd_data)
  );

  // Arbiter: only consulted in IDLE.
  always_comb begin
    w_pick = G_NONE;
`ifdef MEMCTL_RR_EN
    // The last-granted source is moved to the bottom of the order.
    case (last_q)
      G_DWR: begin
        if (bus.d_read_req)       w_pick = G_DRD;
        else if (bus.i_read_req)  w_pick = G_IRD;
        else if (bus.d_write_req) w_pick = G_DWR;
      end
      G_DRD: begin
        if (bus.i_read_req)       w_pick = G_IRD;
        else if (bus.d_write_req) w_pick = G_DWR;
        else if (bus.d_read_req)  w_pick = G_DRD;
      end
      default: begin
        if (bus.d_write_req)      w_pick = G_DWR;
        else if (bus.d_read_req)  w_pick = G_DRD;
        else if (bus.i_read_req)  w_pick = G_IRD;
      end
    endcase
`else
    if (bus.d_write_req)      w_pick = G_DWR;
    else if (bus.d_read_req)  w_pick = G_DRD;
    else if (bus.i_read_req)  w_pick = G_IRD;
`endif
  end

  always_comb begin
    case (w_pick)
      G_DRD:   w_pick_blk = bus.d_read_addr[31:5];
      G_IRD:   w_pick_blk = bus.i_read_addr[31:5];
      default: w_pick_blk = bus.d_write_addr[31:5];
    endcase
  end

  always_comb begin
    case (grant_q)
      G_DWR:   w_granted_req = bus.d_write_req;
      G_DRD:   w_granted_req = bus.d_read_req;
      G_IRD:   w_granted_req = bus.i_read_req;
      default: w_granted_req = 1'b0;
    endcase
  end

  // Next-state logic. A granted request dropping in WAIT/BEAT aborts the
  // burst; the same low level in DRAIN is the normal end of a burst.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    blk_d   = blk_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    d_rd_d  = d_rd_q;
    i_rd_d  = i_rd_q;
    w_wr_en = 1'b0;
`ifdef MEMCTL_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_pick != G_NONE) begin
          grant_d = w_pick;
          blk_d   = w_pick_blk;
          beat_d  = 3'd0;
          lat_d   = 4'd0;
          state_d = WAIT;
`ifdef MEMCTL_RR_EN
          last_d  = w_pick;
`endif
        end
      end
      WAIT: begin
        if (!w_granted_req) begin
          state_d = IDLE;
          grant_d = G_NONE;
          beat_d  = 3'd0;
          lat_d   = 4'd0;
        end else if (lat_q == LAT_LAST) begin
          state_d = BEAT;
          lat_d   = 4'd0;
          // Read word is captured on the edge entering BEAT.
          if (grant_q == G_DRD) d_rd_d = w_rd_data;
          if (grant_q == G_IRD) i_rd_d = w_rd_data;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      BEAT: begin
        if (!w_granted_req) begin
          state_d = IDLE;
          grant_d = G_NONE;
          beat_d  = 3'd0;
        end else begin
          w_wr_en = (grant_q == G_DWR);
          if (beat_q == 3'(BURST_LEN - 1)) begin
            state_d = DRAIN;
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = WAIT;
          end
        end
      end
      DRAIN: begin
        if (!w_granted_req) begin
          state_d = IDLE;
          grant_d = G_NONE;
          beat_d  = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= G_NONE;
      blk_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      d_rd_q  <= '0;
      i_rd_q  <= '0;
`ifdef MEMCTL_RR_EN
      last_q  <= G_NONE;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      blk_q   <= blk_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      d_rd_q  <= d_rd_d;
      i_rd_q  <= i_rd_d;
`ifdef MEMCTL_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Vals are gated by the live request so an aborting requester never sees
  // one more beat.
  assign bus.d_write_val = (state_q == BEAT) && (grant_q == G_DWR) && bus.d_write_req;
  assign bus.d_read_val  = (state_q == BEAT) && (grant_q == G_DRD) && bus.d_read_req;
  assign bus.i_read_val  = (state_q == BEAT) && (grant_q == G_IRD) && bus.i_read_req;
  assign bus.d_read_data = d_rd_q;
  assign bus.i_read_data = i_rd_q;

  a_lat_legal: assert property (@(posedge clk) (ACCESS_LAT >= 1 && ACCESS_LAT <= 15))
    else $error("mem_ctrl: ACCESS_LAT must lie in 1..15");

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Self-checking bench for mem_ctrl: directed burst table,
//                multi-cycle corner sequences and randomized bursts compared
//                against a word-level memory model and a beat schedule.
//  Macros      : MEMCTL_RR_EN - selects round-robin expectations
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;
  import mem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4096;
  localparam int P     = LAT + 1;          // beat period
  localparam int LAST_C = 8 * P + 1;       // drain cycle with req still high

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl #(.ACCESS_LAT(LAT), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_d = '0;
  logic [31:0] last_i = '0;

  typedef struct {
    grant_t      kind;
    logic [31:0] addr;
    logic [31:0] base;   // write data base, or expected read data base
  } vec_t;

  task automatic check32(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int word_idx(input logic [31:0] addr, input int k);
    logic [31:0] a;
    a = (addr & 32'hFFFF_FFE0) | (32'(k) << 2);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  task automatic set_req(input grant_t kind, input logic v, input logic [31:0] addr);
    case (kind)
      G_DWR: begin bus.d_write_req = v; bus.d_write_addr = addr; end
      G_DRD: begin bus.d_read_req  = v; bus.d_read_addr  = addr; end
      G_IRD: begin bus.i_read_req  = v; bus.i_read_addr  = addr; end
      default: ;
    endcase
  endtask

  // Cycle c counts from the grant cycle (IDLE with req high) = 0.
  task automatic check_cycle(input grant_t kind, input int c, input logic [31:0] addr,
                             input logic [31:0] data [8]);
    logic [2:0] ev;
    int k;
    ev = 3'b000;
    if (kind != G_NONE && c >= P && (c % P) == 0 && (c / P) <= 8) begin
      k = c / P - 1;
      case (kind)
        G_DWR: begin ev = 3'b100; ref_mem[word_idx(addr, k)] = data[k]; end
        G_DRD: begin ev = 3'b010; last_d = data[k]; end
        default: begin ev = 3'b001; last_i = data[k]; end
      endcase
    end
    check32("vals{dw,dr,ir}", c, {29'd0, bus.d_write_val, bus.d_read_val, bus.i_read_val},
            {29'd0, ev});
    check32("d_read_data", c, bus.d_read_data, last_d);
    check32("i_read_data", c, bus.i_read_data, last_i);
  endtask

  task automatic run_burst(input grant_t kind, input logic [31:0] addr,
                           input logic [31:0] data [8], input int lead,
                           input int abort_after, input bit chain,
                           input logic [31:0] chain_addr);
    int b;
    set_req(kind, 1'b1, addr);
    for (int c = -lead; c <= LAST_C; c++) begin
      if (kind == G_DWR) begin
        b = (c <= 0) ? 0 : (c - 1) / P;
        if (b > 7) b = 7;
        bus.d_write_data = data[b];
      end
      check_cycle(kind, c, addr, data);
      if (abort_after < 8 && c == abort_after * P + 1) begin
        set_req(kind, 1'b0, addr);
        for (int j = 0; j < 2 * P + 1; j++) begin
          tick();
          check_cycle(G_NONE, c + 1 + j, addr, data);
        end
        return;
      end
      tick();
    end
    set_req(kind, 1'b0, addr);
    if (chain) begin
      set_req(G_DRD, 1'b1, chain_addr);
    end else begin
      check_cycle(G_NONE, LAST_C + 1, addr, data);
      tick();
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] exp [8]);
    for (int k = 0; k < 8; k++) exp[k] = ref_mem[word_idx(addr, k)];
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        tbl [8];
    logic [31:0] d [8];
    logic [31:0] slot_addr [8];
    bit          slot_ok [8];
    grant_t      first, second, kind;
    int          s, ab;

    tbl[0] = '{G_DWR, 32'h0000_0100, 32'h0000_00A0};
    tbl[1] = '{G_DRD, 32'h0000_0100, 32'h0000_00A0};
    tbl[2] = '{G_DWR, 32'h0000_0200, 32'h0000_0055};
    tbl[3] = '{G_DRD, 32'h0000_0200, 32'h0000_0055};
    tbl[4] = '{G_IRD, 32'h0000_011F, 32'h0000_00A0};  // offset bits ignored
    tbl[5] = '{G_DWR, 32'h0000_3FE0, 32'h0000_0070};  // top block of array
    tbl[6] = '{G_IRD, 32'h0000_3FE0, 32'h0000_0070};
    tbl[7] = '{G_DRD, 32'h8000_4100, 32'h0000_00A0};  // aliases block 0x100

    bus.d_write_req = 0; bus.d_write_addr = '0; bus.d_write_data = '0;
    bus.d_read_req  = 0; bus.d_read_addr  = '0;
    bus.i_read_req  = 0; bus.i_read_addr  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check32("reset vals", 0, {29'd0, bus.d_write_val, bus.d_read_val, bus.i_read_val}, 32'd0);
    check32("reset d_read_data", 0, bus.d_read_data, 32'd0);
    check32("reset i_read_data", 0, bus.i_read_data, 32'd0);
    reset = 1'b0;
    tick();

    // Directed table
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 8; k++) d[k] = tbl[t].base + 32'(k);
      run_burst(tbl[t].kind, tbl[t].addr, d, 0, 8, 1'b0, '0);
    end

    // Simultaneous dcache and icache refill requests
`ifdef MEMCTL_RR_EN
    first = G_IRD; second = G_DRD;   // last grant was dcache read
`else
    first = G_DRD; second = G_IRD;
`endif
    set_req(second, 1'b1, (second == G_DRD) ? 32'h200 : 32'h100);
    for (int k = 0; k < 8; k++) d[k] = ((first == G_DRD) ? 32'h55 : 32'hA0) + 32'(k);
    run_burst(first, (first == G_DRD) ? 32'h200 : 32'h100, d, 0, 8, 1'b0, '0);
    for (int k = 0; k < 8; k++) d[k] = ((second == G_DRD) ? 32'h55 : 32'hA0) + 32'(k);
    run_burst(second, (second == G_DRD) ? 32'h200 : 32'h100, d, 0, 8, 1'b0, '0);

    // Write-back held through drain, then refill raised as write falls
    for (int k = 0; k < 8; k++) d[k] = 32'h30 + 32'(k);
    run_burst(G_DWR, 32'h600, d, 0, 8, 1'b1, 32'h600);
    run_burst(G_DRD, 32'h600, d, 1, 8, 1'b0, '0);

    // Reset asserted during beat 3 of a write to 0x200
    for (int k = 0; k < 8; k++) d[k] = 32'hC0 + 32'(k);
    set_req(G_DWR, 1'b1, 32'h200);
    for (int c = 0; c < 4 * P; c++) begin
      bus.d_write_data = d[(c <= 0) ? 0 : (c - 1) / P];
      check_cycle(G_DWR, c, 32'h200, d);
      tick();
    end
    bus.d_write_data = d[3];
    check32("beat3 d_write_val", 4 * P, {31'd0, bus.d_write_val}, 32'd1);
    #1 reset = 1'b1;
    bus.d_write_req = 1'b0;
    #1;
    check32("mid-burst reset vals", 4 * P, {29'd0, bus.d_write_val, bus.d_read_val, bus.i_read_val}, 32'd0);
    check32("mid-burst reset d_read_data", 4 * P, bus.d_read_data, 32'd0);
    check32("mid-burst reset i_read_data", 4 * P, bus.i_read_data, 32'd0);
    last_d = '0; last_i = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    d[0] = 32'hC0; d[1] = 32'hC1; d[2] = 32'hC2; d[3] = 32'h58;
    d[4] = 32'h59; d[5] = 32'h5A; d[6] = 32'h5B; d[7] = 32'h5C;
    run_burst(G_DRD, 32'h200, d, 0, 8, 1'b0, '0);

    // Aborts: read dropped after 1 beat, write dropped after 3 beats
    for (int k = 0; k < 8; k++) d[k] = 32'hA0 + 32'(k);
    run_burst(G_DRD, 32'h100, d, 0, 1, 1'b0, '0);
    for (int k = 0; k < 8; k++) d[k] = 32'hE0 + 32'(k);
    run_burst(G_DWR, 32'h100, d, 0, 3, 1'b0, '0);
    model_read(32'h100, d);
    run_burst(G_IRD, 32'h100, d, 0, 8, 1'b0, '0);

    // Randomized bursts against the memory model
    for (int i = 0; i < 8; i++) begin
      slot_addr[i] = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, DEPTH / 8 - 1)) << 5)
                     | 32'($urandom_range(0, 31));
      slot_ok[i] = 1'b0;
    end
    for (int it = 0; it < 24; it++) begin
      s = $urandom_range(0, 7);
      case ($urandom_range(0, 2))
        0: kind = G_DWR;
        1: kind = G_DRD;
        default: kind = G_IRD;
      endcase
      if (!slot_ok[s]) kind = G_DWR;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : 8;
      if (kind == G_DWR) begin
        for (int k = 0; k < 8; k++) d[k] = $urandom;
      end else begin
        model_read(slot_addr[s], d);
      end
      run_burst(kind, slot_addr[s], d, 0, ab, 1'b0, '0);
      if (kind == G_DWR && ab == 8) slot_ok[s] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ACCESS_LAT, default 2, SHALL set the wait cycles before each beat; legal range 1..15.
REQ-002 Parameter MEM_DEPTH, default 4096, SHALL set the word count of the backing array; power of two.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous and active-high.
REQ-005 d_write_req  in  1  dcache write-back burst request, level, held until burst completes.
REQ-006 d_write_addr  in  32  dcache write-back block address, 32-byte aligned.
REQ-007 d_write_data  in  32  dcache write word, registered by dcache from its beat count.
REQ-008 d_write_val  out  1  one-cycle pulse per accepted write beat.
REQ-009 d_read_req / d_read_addr  in  1/32  dcache refill request and block address.
REQ-010 d_read_data / d_read_val  out  32/1  refill word and its one-cycle valid pulse.
REQ-011 i_read_req / i_read_addr  in  1/32  icache refill request and block address.
REQ-012 i_read_data / i_read_val  out  32/1  icache refill word and valid pulse.

Function
REQ-013 Burst SHALL be 8 beats; beat k address = {addr[31:5], k[2:0], 2'b00}; array index = beat address[log2(MEM_DEPTH)+1:2].
REQ-014 States: IDLE, WAIT, BEAT, DRAIN.
REQ-015 IDLE: any request sampled high -> grant one requester, latch its address, beat=0, lat count=0 -> WAIT.
REQ-016 WAIT: ACCESS_LAT cycles, then BEAT; read data for beat k SHALL be loaded into the granted *_read_data register on the edge entering BEAT.
REQ-017 BEAT: exactly one cycle with the granted *_val high; write grants SHALL write d_write_data to the array at the current beat address in this cycle.
REQ-018 After BEAT, beat<7 -> WAIT with beat+1; beat==7 -> DRAIN.
REQ-019 DRAIN: no val; stay until granted req is low, then IDLE. The requester holds req one cycle after the 8th val, and the controller SHALL NOT count this as a new burst.
REQ-020 First val SHALL appear ACCESS_LAT+1 cycles after grant; beat period ACCESS_LAT+1; burst length 8*(ACCESS_LAT+1) cycles.
REQ-021 Granted req dropping in WAIT/BEAT SHALL abort to IDLE at the next edge, with no further val and no array write.
REQ-022 d_write_req falling while d_read_req rises in the same cycle (write-back followed by refill) SHALL give the read burst after DRAIN->IDLE with no lost request.
REQ-023 Only the granted requester's val SHALL ever pulse; at most one val per cycle.
REQ-024 *_read_data SHALL hold its value outside BEAT.

Reset
REQ-025 Reset SHALL force IDLE, all val outputs 0, all read_data 0, counters 0, grant cleared, at any point including mid-burst.
REQ-026 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 MEMCTL_RR_EN defined: round-robin arbitration; last-granted requester has lowest priority among the three request sources.
REQ-028 MEMCTL_RR_EN undefined: fixed priority d_write_req > d_read_req > i_read_req.

Structure
REQ-029 Package mem_pkg SHALL hold BURST_LEN=8, the state enum, and the grant enum (G_NONE, G_DWR, G_DRD, G_IRD).
REQ-030 Sub-module mem_array SHALL provide a MEM_DEPTH x 32 array with synchronous write and combinational read, no reset.
REQ-031 A simulation assertion SHALL flag ACCESS_LAT==0.

Verification
REQ-032 Preload word 0x100+4k = 0xA0+k; d_read_req at 0x100, LAT=2 -> d_read_val at cycles 3,6,...,24 with data 0xA0..0xA7, then DRAIN.
REQ-033 d_write_req at 0x200 with data 0x55+k per beat -> 8 d_write_val pulses; a following read of 0x200 returns 0x55..0x5C.
REQ-034 d_write_req high through DRAIN, then falls while d_read_req rises -> exactly 8 write vals, then the read burst; no ninth val.
REQ-035 d_read_req and i_read_req both high at once, fixed priority -> dcache served first, icache next; with MEMCTL_RR_EN and last grant dcache -> icache first.
REQ-036 Reset at beat 3 of a write -> vals drop immediately, state IDLE, beats 0..2 persist in the array and beats 3..7 are unchanged.
